// File: rtl/apb_sram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_sram_pkg                                                         |
// | Shared FSM state type, wait counter width and byte parity helper.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package apb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int c_cnt_w = 4;

  // Even parity: stored bit makes the total count of ones in byte+bit even.
  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_sram_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_sram_array                                                       |
// | Single-port word memory, byte-strobe write, registered read.         |
// | APB_SRAM_PARITY_EN adds a stored even-parity bit per byte.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apb_sram_array
  import apb_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    we,
  input  logic                    clr,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    perr
);

  localparam int c_nb = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < c_nb; b++) begin
        if (strb[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register holds until the next read; clr forces zero for bad addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (clr) begin
      r_rdata <= '0;
    end else if (en && !we) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

`ifdef APB_SRAM_PARITY_EN
  logic [c_nb-1:0] r_par [DEPTH];
  logic [c_nb-1:0] r_rpar;
  logic            r_rd;
  logic [c_nb-1:0] w_bad;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < c_nb; b++) begin
        if (strb[b]) r_par[addr][b] <= parity8(wdata[8*b +: 8]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpar <= '0;
      r_rd   <= 1'b0;
    end else begin
      r_rd <= en && !we;
      if (en && !we) r_rpar <= r_par[addr];
    end
  end

  always_comb begin
    w_bad = '0;
    for (int b = 0; b < c_nb; b++) begin
      w_bad[b] = r_rpar[b] ^ parity8(r_rdata[8*b +: 8]);
    end
  end

  // Flag is live only in the cycle right after a read, i.e. while PREADY=1.
  assign perr = r_rd && (|w_bad);
`else
  assign perr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/apb_sram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_sram                                                             |
// | APB slave SRAM with configurable wait states; optional byte parity   |
// | via APB_SRAM_PARITY_EN.                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apb_sram
  import apb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int c_lsb  = $clog2(DATA_WIDTH / 8);
  localparam int c_idxw = ADDR_WIDTH - c_lsb;
  localparam int c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_load =
    (WAIT_STATES > 0) ? c_cnt_w'(WAIT_STATES - 1) : '0;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_pready;
  logic               r_pslverr;
  logic               r_armed;

  logic [c_idxw-1:0]  w_idx;
  logic               w_oor;
  logic               w_access;
  logic               w_start;
  logic               w_commit;
  logic               w_perr;
  logic               w_unused;

  assign w_idx    = PADDR[ADDR_WIDTH-1:c_lsb];
  assign w_oor    = (int'(w_idx) >= DEPTH);
  assign w_access = PSEL && PENABLE;
  assign w_start  = (r_state == IDLE) && w_access && r_armed;
  // w_commit marks the edge entering DONE: memory write and read capture happen here.
  assign w_commit = (w_start && (WAIT_STATES == 0)) ||
                    ((r_state == WAIT) && w_access && (r_cnt == '0));
  assign w_unused = &{1'b0, PADDR};

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_armed   <= 1'b1;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      if (!PENABLE) r_armed <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_start && !w_commit) begin
            r_state <= WAIT;
            r_cnt   <= c_wait_load;
          end
        end
        WAIT: begin
          if (!w_access) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (!w_commit) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_commit) begin
        r_state   <= DONE;
        r_cnt     <= '0;
        r_pready  <= 1'b1;
        r_pslverr <= w_oor;
        r_armed   <= 1'b0;
      end
    end
  end

  apb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (c_aw)
  ) u_array (
    .clk   (PCLK),
    .rst_n (PRESET),
    .en    (w_commit && !w_oor),
    .we    (PWRITE),
    .clr   (w_commit && w_oor && !PWRITE),
    .addr  (w_idx[c_aw-1:0]),
    .wdata (PWDATA),
    .strb  (PSTRB),
    .rdata (PRDATA),
    .perr  (w_perr)
  );

  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr || w_perr;

endmodule
`default_nettype wire

// File: tb/tb_apb_sram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_sram                                                          |
// | Directed bench: three apb_sram instances with 0, 3 and 5 wait states.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_apb_sram;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [11:0] PADDR = '0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic        psel    [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    apb_sram #(
      .ADDR_WIDTH  (12),
      .DATA_WIDTH  (32),
      .DEPTH       (256),
      .WAIT_STATES ((i == 0) ? 0 : ((i == 1) ? 3 : 5))
    ) u_dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PADDR   (PADDR),
      .PSEL    (psel[i]),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .PSTRB   (PSTRB),
      .PRDATA  (prdata[i]),
      .PREADY  (pready[i]),
      .PSLVERR (pslverr[i])
    );
  end

  // One APB transfer; returns at the negedge inside the PREADY=1 cycle.
  task automatic xfer(input int d, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int lowc);
    bit got;
    got = 1'b0;
    @(negedge PCLK);
    for (int k = 0; k < 3; k++) psel[k] = 1'b0;
    psel[d] = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = addr; PWDATA = wd; PSTRB = strb;
    @(negedge PCLK);
    PENABLE = 1'b1;
    lowc = 0; rd = '0; err = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (pready[d]) begin
        got = 1'b1; rd = prdata[d]; err = pslverr[d];
      end else begin
        lowc++;
        @(negedge PCLK);
      end
    end
    if (!got) begin
      bad++; total++;
      $display("FAIL xfer_timeout dut=%0d addr=%h pready=%b want=1", d, addr, pready[d]);
    end
  endtask

  task automatic apb_idle();
    @(negedge PCLK);
    for (int k = 0; k < 3; k++) psel[k] = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge PCLK);
    for (int d = 0; d < 3; d++) begin
      if (pready[d] !== 1'b0) begin bad++; $display("FAIL rst_pready dut=%0d got=%b want=0", d, pready[d]); end
      total++;
      if (pslverr[d] !== 1'b0) begin bad++; $display("FAIL rst_pslverr dut=%0d got=%b want=0", d, pslverr[d]); end
      total++;
      if (prdata[d] !== 32'h0) begin bad++; $display("FAIL rst_prdata dut=%0d got=%h want=0", d, prdata[d]); end
      total++;
    end
    PRESET = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic err; int lowc;
    xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, rd, err, lowc);
    if (lowc !== 1) begin bad++; $display("FAIL basic_wr_lat got=%0d want=1", lowc); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL basic_wr_err got=%b want=0", err); end
    total++;
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, rd, err, lowc);
    if (lowc !== 1) begin bad++; $display("FAIL basic_rd_lat got=%0d want=1", lowc); end
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd_data got=%h want=deadbeef", rd); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL basic_rd_err got=%b want=0", err); end
    total++;
    apb_idle();
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int lowc;
    xfer(0, 1'b1, 12'h010, 32'h11223344, 4'hF, rd, err, lowc);
    xfer(0, 1'b1, 12'h010, 32'hAABBCCDD, 4'h5, rd, err, lowc);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, lowc);
    if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strb5_data got=%h want=11bb33dd", rd); end
    total++;
    xfer(0, 1'b1, 12'h010, 32'hAABBCCDD, 4'h0, rd, err, lowc);
    if (err !== 1'b0) begin bad++; $display("FAIL strb0_err got=%b want=0", err); end
    total++;
    if (prdata[0] !== 32'h11BB33DD) begin bad++; $display("FAIL prdata_hold got=%h want=11bb33dd", prdata[0]); end
    total++;
    xfer(0, 1'b0, 12'h010, 32'h0, 4'hF, rd, err, lowc);
    if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strb0_data got=%h want=11bb33dd", rd); end
    total++;
    apb_idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int lowc;
    xfer(1, 1'b1, 12'h008, 32'h0F0F0F0F, 4'hF, rd, err, lowc);
    if (lowc !== 4) begin bad++; $display("FAIL ws3_wr_lat got=%0d want=4", lowc); end
    total++;
    apb_idle();
    if (pready[1] !== 1'b0) begin bad++; $display("FAIL ws3_ready_width got=%b want=0", pready[1]); end
    total++;
    xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, rd, err, lowc);
    if (lowc !== 4) begin bad++; $display("FAIL ws3_rd_lat got=%0d want=4", lowc); end
    total++;
    if (rd !== 32'h0F0F0F0F) begin bad++; $display("FAIL ws3_rd_data got=%h want=0f0f0f0f", rd); end
    total++;
    apb_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lowc; int t0;
    xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, rd, err, lowc);
    t0 = cyc;
    xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, rd, err, lowc);
    if (cyc - t0 !== 6) begin bad++; $display("FAIL b2b_ws3 got=%0d want=6", cyc - t0); end
    total++;
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, rd, err, lowc);
    t0 = cyc;
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, rd, err, lowc);
    if (cyc - t0 !== 3) begin bad++; $display("FAIL b2b_ws0 got=%0d want=3", cyc - t0); end
    total++;
    apb_idle();
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int lowc;
    xfer(0, 1'b1, 12'h000, 32'h5A5A5A5A, 4'hF, rd, err, lowc);
    xfer(0, 1'b1, 12'h400, 32'hFFFFFFFF, 4'hF, rd, err, lowc);
    if (err !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b want=1", err); end
    total++;
    if (lowc !== 1) begin bad++; $display("FAIL oor_wr_lat got=%0d want=1", lowc); end
    total++;
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, err, lowc);
    if (rd !== 32'h5A5A5A5A) begin bad++; $display("FAIL oor_word0 got=%h want=5a5a5a5a", rd); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL inrange_err got=%b want=0", err); end
    total++;
    xfer(0, 1'b0, 12'h400, 32'h0, 4'h0, rd, err, lowc);
    if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd_data got=%h want=0", rd); end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b want=1", err); end
    total++;
    apb_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int lowc; int highs;
    xfer(2, 1'b1, 12'h000, 32'h01020304, 4'hF, rd, err, lowc);
    if (lowc !== 6) begin bad++; $display("FAIL ws5_lat got=%0d want=6", lowc); end
    total++;
    apb_idle();
    // Drop PSEL mid-WAIT.
    @(negedge PCLK);
    psel[2] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000;
    PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK); psel[2] = 1'b0;
    highs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge PCLK);
      if (pready[2]) highs++;
    end
    if (highs !== 0) begin bad++; $display("FAIL abort_pready got=%0d want=0", highs); end
    total++;
    PENABLE = 1'b0;
    xfer(2, 1'b0, 12'h000, 32'h0, 4'h0, rd, err, lowc);
    if (rd !== 32'h01020304) begin bad++; $display("FAIL abort_nowrite got=%h want=01020304", rd); end
    total++;
    apb_idle();
    // Reset mid-WAIT.
    @(negedge PCLK);
    psel[2] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000;
    PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK); PRESET = 1'b0;
    #1;
    if (prdata[2] !== 32'h0) begin bad++; $display("FAIL rstwait_prdata got=%h want=0", prdata[2]); end
    total++;
    if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0) begin
      bad++; $display("FAIL rstwait_flags got=%b%b want=00", pready[2], pslverr[2]);
    end
    total++;
    psel[2] = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); PRESET = 1'b1;
    xfer(2, 1'b0, 12'h000, 32'h0, 4'h0, rd, err, lowc);
    if (rd !== 32'h01020304) begin bad++; $display("FAIL rstwait_nowrite got=%h want=01020304", rd); end
    total++;
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, rd, err, lowc);
    if (rd !== 32'hDEADBEEF || lowc !== 1) begin
      bad++; $display("FAIL mem_kept got=%h/%0d want=deadbeef/1", rd, lowc);
    end
    total++;
    apb_idle();
  endtask

`ifdef APB_SRAM_PARITY_EN
  task automatic test_parity();
    logic [31:0] rd; logic err; int lowc;
    xfer(0, 1'b1, 12'h020, 32'hCAFEF00D, 4'hF, rd, err, lowc);
    apb_idle();
    g_dut[0].u_dut.u_array.r_par[8][1] = ~g_dut[0].u_dut.u_array.r_par[8][1];
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, rd, err, lowc);
    if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL par_data got=%h want=cafef00d", rd); end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL par_err got=%b want=1", err); end
    total++;
    apb_idle();
  endtask
`endif

  initial begin
    for (int k = 0; k < 3; k++) psel[k] = 1'b0;
    test_reset();
    test_basic();
    test_strobe();
    test_wait_states();
    test_back_to_back();
    test_out_of_range();
    test_abort();
`ifdef APB_SRAM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed=%0t want=finish", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
